dwt_coeff_collector: RTL

- Sits directly downstream of the low-pass and high-pass Daubechies-10 convolution pair (MODE=0 and MODE=1, same input stream).
- Performs the keep side of the ÷2 downsampling: captures an {approximation, detail} coefficient pair only on cycles where both filters assert parity.
- Frames pairs into blocks of FRAME_LEN and buffers them in a FIFO that the AIRISC-side bus wrapper drains.

---
 rtl/dwt_coeff_collector_pkg.sv | 14 +
 rtl/dwt_sync_fifo.sv | 61 ++++++
 rtl/dwt_coeff_collector.sv | 102 ++++++++++
 3 files changed

// File: rtl/dwt_coeff_collector_pkg.sv
// Shared constants and FSM state encoding for the DWT coefficient collector slice.
package dwt_coeff_collector_pkg;

  localparam int DWT_DATA_W     = 32;
  localparam int DWT_FIFO_DEPTH = 64;
  localparam int DWT_FRAME_LEN  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/dwt_sync_fifo.sv
// Single-clock FIFO with registered read port; extra pointer MSB separates full from empty.
module dwt_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             push, pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count = wr_ptr_q - rd_ptr_q;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    pop   = rd_en & ~empty;
    push  = wr_en & (~full | pop);
    wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rd_data_d  = pop  ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    rd_valid_d = pop;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/dwt_coeff_collector.sv
// Keeps {detail, approximation} pairs on joint parity strobes, frames them, and buffers them for the bus side.
module dwt_coeff_collector
  import dwt_coeff_collector_pkg::*;
#(
  parameter int DATA_W    = DWT_DATA_W,
  parameter int DEPTH     = DWT_FIFO_DEPTH,
  parameter int FRAME_LEN = DWT_FRAME_LEN
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        lo_data,
  input  logic                     lo_parity,
  input  logic [DATA_W-1:0]        hi_data,
  input  logic                     hi_parity,
  input  logic                     frame_start,
  input  logic                     rd_en,
  output logic [2*DATA_W-1:0]      rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     sync_err
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] pair_cnt_q, pair_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;
  logic        sync_err_q, sync_err_d;
  logic        take, mismatch, drop;

  dwt_sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (take),
    .wr_data  ({hi_data, lo_data}),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always_comb begin
    take     = lo_parity & hi_parity & (state_q == ST_COLLECT);
    mismatch = lo_parity ^ hi_parity;
    // Full implies non-empty, so a same-cycle rd_en is always an accepted pop.
    drop     = take & full & ~rd_en;

    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q;
    frame_done_d = 1'b0;

    overflow_d = frame_start ? 1'b0 : overflow_q;
    if (drop) overflow_d = 1'b1;
    sync_err_d = frame_start ? 1'b0 : sync_err_q;
    if (mismatch) sync_err_d = 1'b1;

    // A restart takes priority over a frame's final take; that take is still written.
    if (frame_start) begin
      state_d    = ST_COLLECT;
      pair_cnt_d = '0;
    end else if (take) begin
      pair_cnt_d = pair_cnt_q + 16'd1;
      if (pair_cnt_q == LAST_IDX) begin
        state_d      = ST_DONE;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      pair_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign busy       = (state_q == ST_COLLECT);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

endmodule
